uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver FSM. It captures each byte the receiver qualifies with its one-cycle ready strobe, holds up to DEPTH bytes in order, and presents them to the host side through a first-word-fall-through pop interface. Overrun is flagged stickily, and frame errors are optionally counted, so the host can service the link in bursts without losing status.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- AFULL_LEVEL, DEPTH-4, level at or above which almost_full asserts; 1..DEPTH

- clk_50mhz  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- rx_data_in  in  8  byte from receiver (its rx_data_out)
- rx_ready  in  1  one-cycle push strobe from receiver
- rx_error  in  1  one-cycle frame-error strobe from receiver
- rd_en  in  1  pop head entry
- ovr_clr  in  1  clear sticky overrun flag
- rd_data  out  8  head entry, valid while empty=0
- empty  out  1  no entries
- full  out  1  DEPTH entries
- almost_full  out  1  level ≥ AFULL_LEVEL
- level  out  $clog2(DEPTH)+1  current entry count
- overrun  out  1  sticky: a push was dropped
- ovr_cnt  out  8  dropped-push count (stats build only)
- ferr_cnt  out  8  frame-error count (stats build only)
- stats_clr  in  1  zero both counters (stats build only)

## Operation
- Storage: DEPTH×8 register array; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap), and level counter.
- Push: rx_ready=1 and (full=0 or rd_en=1) → write rx_data_in at wptr, wptr+1.
- Pop: rd_en=1 and empty=0 → rptr+1. rd_en while empty is ignored, with no state change.
- Level: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full with simultaneous push and pop: both accepted; level stays DEPTH.
- Empty with simultaneous push and pop: pop ignored, push accepted; level becomes 1.
- Full with push and no pop: byte dropped, contents unchanged, overrun←1, ovr_cnt+1.
- overrun stays set until ovr_clr=1. If a drop and ovr_clr occur in the same cycle, the drop wins and overrun stays 1.
- rx_error never writes data. It only increments ferr_cnt in the stats build.
- Counters saturate at 255. stats_clr has priority over a same-cycle increment, so the counter reads 0.
- rx_ready and rx_error are assumed mutually exclusive. If both are high, both actions occur.

## Timing
- Reset (rst_n=0 at an edge) sets: pointers=0, level=0, empty=1, full=0, almost_full=0, overrun=0, ovr_cnt=0, ferr_cnt=0, rd_data=8'h00. Array contents are not reset.
- rd_data is a combinational read of array[rptr], forced to 8'h00 when empty.
- A reset asserted mid-stream discards all entries on that edge.
- Push-to-visible latency: 1 cycle. Push at edge N gives empty=0 and the new rd_data after edge N.
- Pop: head advances after the edge where rd_en=1 is sampled. rd_data shows the next entry the same cycle.
- empty, full, almost_full, and level are all registered or derived from registered level, and are mutually consistent every cycle.

## Configuration
- UART_RX_FIFO_STATS_EN defined: ovr_cnt, ferr_cnt, and stats_clr are present and behave as above.
- Not defined: those three ports are absent; rx_error is accepted and ignored; overrun works identically.

## Structure
- Shared package uart_pkg holds: UART_DATA_W=8, UART_STAT_W=8, and a level-width helper function.
- One sub-module, uart_sat_cnt: a UART_STAT_W-bit saturating counter with inc and clr inputs (clr priority), instantiated twice under UART_RX_FIFO_STATS_EN.

## Test plan
- Reset, then push 8'hA5 and later 8'h3C with no pops → after 2 pushes level=2, rd_data=8'hA5. Pop → rd_data=8'h3C. Pop → empty=1, rd_data=8'h00.
- Push 16 bytes 0x00..0x0F (DEPTH=16) → almost_full from the 12th push, full at the 16th. A 17th push of 0xFF → dropped, overrun=1, ovr_cnt=1. Drain 16 pops → returns 0x00..0x0F in order.
- At full, push 0x55 together with rd_en → level stays 16. After a full drain, the last byte read is 0x55. overrun stays 0.
- When empty, push 0x77 together with rd_en → level=1, rd_data=0x77 next cycle.
- 3 rx_error pulses, then stats_clr in the same cycle as a 4th rx_error → ferr_cnt goes 1,2,3, then 0. 300 pulses → ferr_cnt saturates at 255.
- Fill 5 entries, assert rst_n=0 for one edge → level=0, empty=1, overrun=0. A following push of 0x12 reads back as 0x12.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths and the FIFO level-width helper.
//   UART_DATA_W  byte width carried by the receive path
//   UART_STAT_W  width of the saturating statistics counters
//   lvl_w()      bits needed to count 0..depth entries
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int UART_STAT_W = 8;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-to-host bus around the receive FIFO.
//   rx_data_in/rx_ready/rx_error  receiver strobes into the FIFO
//   rd_en/ovr_clr                 host pop and overrun clear
//   rd_data/empty/full/almost_full/level/overrun  FIFO status to host
//   stats_clr/ovr_cnt/ferr_cnt    statistics, only with UART_RX_FIFO_STATS_EN
//   master: the side feeding the FIFO; slave: the FIFO itself
interface uart_rx_fifo_if import uart_pkg::*; #(parameter int DEPTH = 16);
    logic [UART_DATA_W-1:0] rx_data_in;
    logic                   rx_ready;
    logic                   rx_error;
    logic                   rd_en;
    logic                   ovr_clr;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   empty;
    logic                   full;
    logic                   almost_full;
    logic [lvl_w(DEPTH)-1:0] level;
    logic                   overrun;
`ifdef UART_RX_FIFO_STATS_EN
    logic                   stats_clr;
    logic [UART_STAT_W-1:0] ovr_cnt;
    logic [UART_STAT_W-1:0] ferr_cnt;
`endif

    modport master (
        output rx_data_in, rx_ready, rx_error, rd_en, ovr_clr,
        input  rd_data, empty, full, almost_full, level, overrun
`ifdef UART_RX_FIFO_STATS_EN
        , output stats_clr, input ovr_cnt, ferr_cnt
`endif
    );

    modport slave (
        input  rx_data_in, rx_ready, rx_error, rd_en, ovr_clr,
        output rd_data, empty, full, almost_full, level, overrun
`ifdef UART_RX_FIFO_STATS_EN
        , input stats_clr, output ovr_cnt, ferr_cnt
`endif
    );
endinterface

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: UART_STAT_W-bit counter that sticks at all-ones; clr beats inc.
//   clk_50mhz, rst_n  clock and synchronous active-low reset
//   inc               count one event
//   clr               zero the counter
//   cnt               current count
module uart_sat_cnt import uart_pkg::*; (
    input  logic                   clk_50mhz,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    output logic [UART_STAT_W-1:0] cnt
);
    always_ff @(posedge clk_50mhz)
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + UART_STAT_W'(1);
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver.
//   clk_50mhz, rst_n  clock and synchronous active-low reset
//   bus               uart_rx_fifo_if slave: receiver strobes in, host pop/status out
//   DEPTH             entries (power of two, >= 2); AFULL_LEVEL almost_full threshold
//   Define UART_RX_FIFO_STATS_EN to add the overrun/frame-error counters.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic          clk_50mhz,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AFULL_LEVEL);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LW-1:0] lvl;
    logic          ovr;
    logic          push, pop, drop;

    // a same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign pop  = bus.rd_en && lvl != '0;
    assign push = bus.rx_ready && (lvl != FULL_L || bus.rd_en);
    assign drop = bus.rx_ready && lvl == FULL_L && !bus.rd_en;

    always_ff @(posedge clk_50mhz)
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
            ovr  <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= bus.rx_data_in;
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            lvl <= (push && !pop) ? lvl + LW'(1) : (pop && !push) ? lvl - LW'(1) : lvl;
            // a drop in the same cycle as the clear keeps the flag set
            ovr <= drop || (ovr && !bus.ovr_clr);
        end

    assign bus.empty       = lvl == '0;
    assign bus.full        = lvl == FULL_L;
    assign bus.almost_full = lvl >= AF_L;
    assign bus.level       = lvl;
    assign bus.overrun     = ovr;
    assign bus.rd_data     = (lvl == '0) ? '0 : mem[rptr];

`ifdef UART_RX_FIFO_STATS_EN
    uart_sat_cnt u_ovr_cnt (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .inc(drop),
        .clr(bus.stats_clr), .cnt(bus.ovr_cnt)
    );
    uart_sat_cnt u_ferr_cnt (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .inc(bus.rx_error),
        .clr(bus.stats_clr), .cnt(bus.ferr_cnt)
    );
`else
    // frame errors carry no data and are only counted in the stats build
    logic unused_rx_error;
    assign unused_rx_error = bus.rx_error;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (DEPTH=16, AFULL_LEVEL=12).
module tb_uart_rx_fifo;
    logic clk_50mhz = 1'b0;
    logic rst_n     = 1'b0;
    int   total     = 0;
    int   passed    = 0;
    int   errors    = 0;

    uart_rx_fifo_if #(.DEPTH(16)) bus ();

    uart_rx_fifo #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk_50mhz(clk_50mhz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic cyc();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_data_in = b;
        bus.rx_ready   = 1'b1;
        cyc();
        bus.rx_ready   = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.rx_data_in = 8'h00;
        bus.rx_ready   = 1'b0;
        bus.rx_error   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.ovr_clr    = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
        bus.stats_clr  = 1'b0;
`endif
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("rst_ovr_cnt", 32'(bus.ovr_cnt), 0);
        chk("rst_ferr_cnt", 32'(bus.ferr_cnt), 0);
`endif

        push(8'hA5);
        chk("p1_level", 32'(bus.level), 1);
        chk("p1_rd_data", 32'(bus.rd_data), 32'hA5);
        chk("p1_empty", 32'(bus.empty), 0);
        cyc();
        push(8'h3C);
        chk("p2_level", 32'(bus.level), 2);
        chk("p2_rd_data", 32'(bus.rd_data), 32'hA5);
        pop();
        chk("pop1_rd_data", 32'(bus.rd_data), 32'h3C);
        chk("pop1_level", 32'(bus.level), 1);
        pop();
        chk("pop2_empty", 32'(bus.empty), 1);
        chk("pop2_rd_data", 32'(bus.rd_data), 0);
        pop();
        chk("pop_empty_level", 32'(bus.level), 0);
        chk("pop_empty_empty", 32'(bus.empty), 1);

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_level", 32'(bus.level), 32'(i + 1));
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 11));
            chk("fill_full", 32'(bus.full), 32'(i == 15));
        end
        chk("fill_overrun", 32'(bus.overrun), 0);
        push(8'hFF);
        chk("drop_overrun", 32'(bus.overrun), 1);
        chk("drop_level", 32'(bus.level), 16);
        chk("drop_rd_data", 32'(bus.rd_data), 0);
`ifdef UART_RX_FIFO_STATS_EN
        chk("drop_ovr_cnt", 32'(bus.ovr_cnt), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            chk("drain_rd_data", 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_overrun_sticky", 32'(bus.overrun), 1);
        bus.ovr_clr = 1'b1;
        cyc();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 0);

        for (int i = 0; i < 16; i++) push(8'(32 + i));
        chk("refill_full", 32'(bus.full), 1);
        bus.rd_en = 1'b1;
        push(8'h55);
        bus.rd_en = 1'b0;
        chk("pushpop_full_level", 32'(bus.level), 16);
        chk("pushpop_full_overrun", 32'(bus.overrun), 0);
        chk("pushpop_full_head", 32'(bus.rd_data), 32'h21);
        bus.ovr_clr = 1'b1;
        push(8'h99);
        bus.ovr_clr = 1'b0;
        chk("drop_vs_clr_overrun", 32'(bus.overrun), 1);
        chk("drop_vs_clr_level", 32'(bus.level), 16);
`ifdef UART_RX_FIFO_STATS_EN
        chk("drop_vs_clr_ovr_cnt", 32'(bus.ovr_cnt), 2);
`endif
        bus.ovr_clr = 1'b1;
        cyc();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr2", 32'(bus.overrun), 0);
        for (int i = 0; i < 15; i++) begin
            chk("drain2_rd_data", 32'(bus.rd_data), 32'(33 + i));
            pop();
        end
        chk("drain2_last", 32'(bus.rd_data), 32'h55);
        pop();
        chk("drain2_empty", 32'(bus.empty), 1);

        bus.rd_en = 1'b1;
        push(8'h77);
        bus.rd_en = 1'b0;
        chk("pushpop_empty_level", 32'(bus.level), 1);
        chk("pushpop_empty_rd_data", 32'(bus.rd_data), 32'h77);
        pop();
        chk("pushpop_empty_drain", 32'(bus.empty), 1);

        bus.rx_error = 1'b1;
        cyc();
        bus.rx_error = 1'b0;
        chk("rx_error_no_write", 32'(bus.empty), 1);
`ifdef UART_RX_FIFO_STATS_EN
        chk("ferr_1", 32'(bus.ferr_cnt), 1);
        for (int i = 2; i <= 3; i++) begin
            bus.rx_error = 1'b1;
            cyc();
            bus.rx_error = 1'b0;
            chk("ferr_n", 32'(bus.ferr_cnt), 32'(i));
        end
        bus.rx_error  = 1'b1;
        bus.stats_clr = 1'b1;
        cyc();
        bus.rx_error  = 1'b0;
        bus.stats_clr = 1'b0;
        chk("ferr_clr_wins", 32'(bus.ferr_cnt), 0);
        chk("ovr_cnt_clr", 32'(bus.ovr_cnt), 0);
        bus.rx_error = 1'b1;
        for (int i = 0; i < 300; i++) cyc();
        bus.rx_error = 1'b0;
        chk("ferr_sat", 32'(bus.ferr_cnt), 255);
`endif

        for (int i = 0; i < 5; i++) push(8'(64 + i));
        chk("pre_rst_level", 32'(bus.level), 5);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_rst_level", 32'(bus.level), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_overrun", 32'(bus.overrun), 0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        push(8'h12);
        chk("post_rst_rd_data", 32'(bus.rd_data), 32'h12);
        chk("post_rst_level", 32'(bus.level), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
